// File: rtl/alu_pkg.sv
// Shared types and the NZCV flag helper for alu_mc and its multiplier.
package alu_pkg;

  // Op codes. Unlisted codes are undefined and produce a zero result.
  typedef enum logic [3:0] {
    OP_AND   = 4'd0,
    OP_ORR   = 4'd1,
    OP_ADD   = 4'd2,
    OP_EOR   = 4'd3,
    OP_LSL   = 4'd4,
    OP_LSR   = 4'd5,
    OP_SUB   = 4'd6,
    OP_PASSB = 4'd7,
    OP_MUL   = 4'd8,
    OP_NOR   = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // N and Z come from the result alone. C and V only mean something for ADD/SUB.
  // For SUB the carry is "not borrow", i.e. A >= B unsigned.
  function automatic flags_t flags_f(input logic [3:0] op,
                                     input logic       res_zero,
                                     input logic       res_msb,
                                     input logic       a_msb,
                                     input logic       b_msb,
                                     input logic       add_cout,
                                     input logic       a_ge_b);
    flags_t f;
    f.n = res_msb;
    f.z = res_zero;
    f.c = 1'b0;
    f.v = 1'b0;
    case (op)
      OP_ADD: begin
        f.c = add_cout;
        f.v = (a_msb == b_msb) && (res_msb != a_msb);
      end
      OP_SUB: begin
        f.c = a_ge_b;
        f.v = (a_msb != b_msb) && (res_msb != a_msb);
      end
      default: begin
        f.c = 1'b0;
        f.v = 1'b0;
      end
    endcase
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add multiplier for alu_mc (low WIDTH bits of A*B).
// Only built when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module alu_mul_iter #(
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_step_s;

  // One iteration: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_step_s = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});
  end

  // Product of the final iteration is handed straight to the top in the same cycle.
  assign done_o    = busy_q && (cnt_q == LAST_CNT);
  assign product_o = acc_step_s;

  // Load operands on start, then iterate once per cycle until WIDTH bits are consumed.
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start_i) begin
      busy_d   = 1'b1;
      cnt_d    = {CNT_W{1'b0}};
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = {WIDTH{1'b0}};
    end else if (busy_q) begin
      acc_d    = acc_step_s;
      mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
      cnt_d    = cnt_q + CNT_W'(1);
      busy_d   = (cnt_q != LAST_CNT);
    end else begin
      busy_d = 1'b0;
    end
  end

  // Iteration state; reset discards any partial product.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q   <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule
`endif

// File: rtl/alu_mc.sv
// Multi-cycle LEGv8 ALU with NZCV flags and valid/ready handshakes on both sides.
// Define ALU_MUL_EN to enable the iterative multiply (op 8); otherwise op 8 is undefined.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_CTRL,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic             ZERO,
  output logic             NEG,
  output logic             CARRY,
  output logic             OVF
);

  localparam int SHAMT_W = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  flags_t           flags_q, flags_d;
  logic             accept_s;
  logic [WIDTH-1:0] res_s;
  logic [WIDTH:0]   add_full_s;
  logic             a_ge_b_s;
  logic [SHAMT_W-1:0] shamt_s;
  flags_t           res_flags_s;

`ifdef ALU_MUL_EN
  logic             mul_start_s;
  logic             mul_done_s;
  logic [WIDTH-1:0] mul_prod_s;
  flags_t           mul_flags_s;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk_i     (CLK),
    .rst_i     (RST),
    .start_i   (mul_start_s),
    .a_i       (A),
    .b_i       (B),
    .done_o    (mul_done_s),
    .product_o (mul_prod_s)
  );

  assign mul_flags_s = flags_f(OP_MUL, (mul_prod_s == {WIDTH{1'b0}}), mul_prod_s[WIDTH-1],
                               1'b0, 1'b0, 1'b0, 1'b0);
`endif

  // A new op fits when nothing is pending, or when the pending result leaves this cycle.
  assign IN_READY  = !RST && ((state_q == IDLE) || ((state_q == DONE) && OUT_READY));
  assign accept_s  = IN_VALID && IN_READY;
  assign OUT_VALID = (state_q == DONE);
  assign ALU_OUT   = out_q;
  assign ZERO      = flags_q.z;
  assign NEG       = flags_q.n;
  assign CARRY     = flags_q.c;
  assign OVF       = flags_q.v;

  // Single-cycle datapath and its flags, computed from the live inputs.
  always_comb begin
    shamt_s    = B[SHAMT_W-1:0];
    add_full_s = {1'b0, A} + {1'b0, B};
    a_ge_b_s   = (A >= B);
    res_s      = {WIDTH{1'b0}};
    case (ALU_CTRL)
      OP_AND:   res_s = A & B;
      OP_ORR:   res_s = A | B;
      OP_ADD:   res_s = add_full_s[WIDTH-1:0];
      OP_EOR:   res_s = A ^ B;
      OP_LSL:   res_s = A << shamt_s;
      OP_LSR:   res_s = A >> shamt_s;
      OP_SUB:   res_s = A - B;
      OP_PASSB: res_s = B;
      OP_NOR:   res_s = ~(A | B);
      default:  res_s = {WIDTH{1'b0}};
    endcase
    res_flags_s = flags_f(ALU_CTRL, (res_s == {WIDTH{1'b0}}), res_s[WIDTH-1],
                          A[WIDTH-1], B[WIDTH-1], add_full_s[WIDTH], a_ge_b_s);
  end

  // Handshake FSM: decides when to capture a result and when to start the multiplier.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    flags_d = flags_q;
`ifdef ALU_MUL_EN
    mul_start_s = 1'b0;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
`ifdef ALU_MUL_EN
          if (ALU_CTRL == OP_MUL) begin
            state_d     = BUSY;
            mul_start_s = 1'b1;
          end else begin
            state_d = DONE;
            out_d   = res_s;
            flags_d = res_flags_s;
          end
`else
          state_d = DONE;
          out_d   = res_s;
          flags_d = res_flags_s;
`endif
        end else if ((state_q == DONE) && OUT_READY) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      BUSY: begin
`ifdef ALU_MUL_EN
        if (mul_done_s) begin
          state_d = DONE;
          out_d   = mul_prod_s;
          flags_d = mul_flags_s;
        end else begin
          state_d = BUSY;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any pending or in-flight result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      out_q   <= {WIDTH{1'b0}};
      flags_q <= '{n: 1'b0, z: 1'b1, c: 1'b0, v: 1'b0};
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=64). Multiply scenarios run when ALU_MUL_EN is defined.
module tb_alu_mc;

  localparam int W  = 64;
  localparam int SH = $clog2(W);
  localparam int N_STREAM = 60;

  logic         CLK = 1'b0;
  logic         RST, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic         ZERO, NEG, CARRY, OVF;
  logic [W-1:0] A, B, ALU_OUT;
  logic [3:0]   ALU_CTRL;
  logic [W+4:0] obs;

  int total = 0;
  int bad   = 0;

  alu_mc #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .ALU_CTRL(ALU_CTRL), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .ALU_OUT(ALU_OUT), .ZERO(ZERO), .NEG(NEG), .CARRY(CARRY), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  assign obs = {OUT_VALID, ALU_OUT, ZERO, NEG, CARRY, OVF};

  // Reference: {result, Z, N, C, V} straight from the op definitions.
  function automatic logic [W+3:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0]        r;
    logic                c, v;
    logic [W:0]          wide;
    logic signed [W+1:0] exact;
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: begin
        wide  = {1'b0, a} + {1'b0, b};
        r     = wide[W-1:0];
        c     = wide[W];
        exact = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b});
        v     = (exact != $signed({{2{r[W-1]}}, r}));
      end
      4'd3: r = a ^ b;
      4'd4: r = a << b[SH-1:0];
      4'd5: r = a >> b[SH-1:0];
      4'd6: begin
        r     = a - b;
        c     = (a >= b);
        exact = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
        v     = (exact != $signed({{2{r[W-1]}}, r}));
      end
      4'd7: r = b;
`ifdef ALU_MUL_EN
      4'd8: r = a * b;
`endif
      4'd12: r = ~(a | b);
      default: r = '0;
    endcase
    return {r, (r == '0), r[W-1], c, v};
  endfunction

  function automatic logic [3:0] pick_op();
    logic [3:0] o;
    o = 4'($urandom_range(0, 15));
`ifdef ALU_MUL_EN
    if (o == 4'd8) o = 4'd6;
`endif
    return o;
  endfunction

  function automatic logic [W-1:0] rand_w();
    case ($urandom_range(0, 9))
      0: return 64'h0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // Present one op from IDLE, let it be accepted, then scramble the inputs.
  task automatic accept_one(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    IN_VALID = 1'b1; ALU_CTRL = op; A = a; B = b;
    tick();
    IN_VALID = 1'b0; ALU_CTRL = pick_op(); A = rand_w(); B = rand_w();
  endtask

  task automatic retire();
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; IN_VALID = 1'b1; ALU_CTRL = 4'd2; A = 64'd5; B = 64'd6; OUT_READY = 1'b0;
    repeat (2) tick();
    total++;
    if (IN_READY !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", IN_READY); end
    RST = 1'b0; IN_VALID = 1'b0;
    #1;
    total++;
    if (obs !== {1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_state got=%h want=%h", obs, {1'b0, 64'h0, 4'b1000});
    end
    total++;
    if (IN_READY !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b want=1", IN_READY); end
  endtask

  task automatic test_directed();
    accept_one(4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    total++;
    if (obs !== {1'b1, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL add_carry got=%h want=%h", obs, {1'b1, 64'h0, 4'b1010});
    end
    retire();
    total++;
    if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL retire_idle got=%b want=0", OUT_VALID); end
    accept_one(4'd6, 64'h8000_0000_0000_0000, 64'd1);
    total++;
    if (obs !== {1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      bad++; $display("FAIL sub_ovf got=%h want=%h", obs, {1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011});
    end
    retire();
    accept_one(4'd9, 64'd5, 64'd5);
    total++;
    if (obs !== {1'b1, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL undef_op9 got=%h want=%h", obs, {1'b1, 64'h0, 4'b1000});
    end
    retire();
`ifndef ALU_MUL_EN
    accept_one(4'd8, 64'd5, 64'd5);
    total++;
    if (obs !== {1'b1, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL op8_no_mul got=%h want=%h", obs, {1'b1, 64'h0, 4'b1000});
    end
    retire();
`endif
  endtask

  task automatic test_random_ops();
    logic [3:0]   op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 150; i++) begin
      op = pick_op(); a = rand_w(); b = rand_w();
      accept_one(op, a, b);
      total++;
      if (obs !== {1'b1, model(op, a, b)}) begin
        bad++; $display("FAIL rand_op%0d a=%h b=%h got=%h want=%h", op, a, b, obs, {1'b1, model(op, a, b)});
      end
      retire();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a0, b0, a2, b2;
    a0 = rand_w(); b0 = rand_w(); a2 = rand_w(); b2 = rand_w();
    OUT_READY = 1'b0;
    IN_VALID = 1'b1; ALU_CTRL = 4'd1; A = a0; B = b0;
    tick();
    ALU_CTRL = 4'd4; A = 64'd1; B = 64'd65;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      total++;
      if ({obs, IN_READY} !== {1'b1, model(4'd1, a0, b0), 1'b0}) begin
        bad++; $display("FAIL stall_hold%0d got=%h want=%h", i, {obs, IN_READY}, {1'b1, model(4'd1, a0, b0), 1'b0});
      end
      tick();
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    total++;
    if (IN_READY !== 1'b1) begin bad++; $display("FAIL drain_in_ready got=%b want=1", IN_READY); end
    tick();
    ALU_CTRL = 4'd12; A = a2; B = b2;
    @(negedge CLK);
    total++;
    if (obs !== {1'b1, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL lsl_wrap got=%h want=%h", obs, {1'b1, 64'd2, 4'b0000});
    end
    tick();
    IN_VALID = 1'b0;
    @(negedge CLK);
    total++;
    if (obs !== {1'b1, model(4'd12, a2, b2)}) begin
      bad++; $display("FAIL nor_order got=%h want=%h", obs, {1'b1, model(4'd12, a2, b2)});
    end
    tick();
    OUT_READY = 1'b0;
    total++;
    if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL stream_end got=%b want=0", OUT_VALID); end
  endtask

  task automatic test_back_to_back();
    logic [W+3:0] exp_q[$];
    int sent = 0, got = 0, cyc = 0;
    while ((sent < N_STREAM || exp_q.size() != 0) && cyc < 2000) begin
      if (sent < N_STREAM) begin
        IN_VALID = ($urandom_range(0, 3) != 0);
        ALU_CTRL = pick_op(); A = rand_w(); B = rand_w();
        OUT_READY = ($urandom_range(0, 2) != 0);
      end else begin
        IN_VALID = 1'b0; OUT_READY = 1'b1;
      end
      @(negedge CLK);
      total++;
      if (OUT_VALID !== (exp_q.size() != 0)) begin
        bad++; $display("FAIL b2b_valid cyc=%0d got=%b want=%b", cyc, OUT_VALID, exp_q.size() != 0);
      end else if (OUT_VALID === 1'b1) begin
        total++;
        if ({ALU_OUT, ZERO, NEG, CARRY, OVF} !== exp_q[0]) begin
          bad++; $display("FAIL b2b_data cyc=%0d got=%h want=%h", cyc, {ALU_OUT, ZERO, NEG, CARRY, OVF}, exp_q[0]);
        end
      end
      total++;
      if (IN_READY !== (!OUT_VALID || OUT_READY)) begin
        bad++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=%b", cyc, IN_READY, !OUT_VALID || OUT_READY);
      end
      if (OUT_VALID && OUT_READY && exp_q.size() != 0) begin
        void'(exp_q.pop_front()); got++;
      end
      if (IN_VALID && IN_READY) begin
        exp_q.push_back(model(ALU_CTRL, A, B)); sent++;
      end
      tick();
      cyc++;
    end
    IN_VALID = 1'b0; OUT_READY = 1'b0;
    total++;
    if (got != N_STREAM || exp_q.size() != 0) begin
      bad++; $display("FAIL b2b_count got=%0d want=%0d", got, N_STREAM);
    end
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul();
    logic [W-1:0] a, b;
    int edges, leaks;
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 64'd13 : rand_w();
      b = (i == 0) ? 64'd11 : rand_w();
      OUT_READY = 1'b0;
      IN_VALID = 1'b1; ALU_CTRL = 4'd8; A = a; B = b;
      tick();
      ALU_CTRL = 4'd2; A = rand_w(); B = rand_w();
      edges = 0; leaks = 0;
      @(negedge CLK);
      while (OUT_VALID !== 1'b1 && edges < 200) begin
        if (IN_READY !== 1'b0) leaks++;
        @(posedge CLK); edges++;
        @(negedge CLK);
      end
      IN_VALID = 1'b0;
      total++;
      if (edges != W) begin bad++; $display("FAIL mul_latency%0d got=%0d want=%0d", i, edges + 1, W + 1); end
      total++;
      if (leaks != 0) begin bad++; $display("FAIL mul_busy_ready%0d got=%0d want=0", i, leaks); end
      total++;
      if (obs !== {1'b1, model(4'd8, a, b)}) begin
        bad++; $display("FAIL mul_result%0d got=%h want=%h", i, obs, {1'b1, model(4'd8, a, b)});
      end
      retire();
    end
  endtask
`endif

  task automatic test_abort();
    int stale;
    OUT_READY = 1'b0;
`ifdef ALU_MUL_EN
    accept_one(4'd8, rand_w(), rand_w());
    repeat (3) tick();
`else
    accept_one(4'd2, 64'd7, 64'd9);
    tick();
`endif
    RST = 1'b1;
    #1;
    total++;
    if (IN_READY !== 1'b0) begin bad++; $display("FAIL abort_in_ready got=%b want=0", IN_READY); end
    tick();
    RST = 1'b0;
    #1;
    total++;
    if (obs !== {1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL abort_state got=%h want=%h", obs, {1'b0, 64'h0, 4'b1000});
    end
    stale = 0;
    for (int i = 0; i < W + 8; i++) begin
      tick();
      if (OUT_VALID !== 1'b0) stale++;
    end
    total++;
    if (stale != 0) begin bad++; $display("FAIL abort_stale got=%0d want=0", stale); end
    accept_one(4'd2, 64'd2, 64'd3);
    total++;
    if (obs !== {1'b1, 64'd5, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL abort_fresh_add got=%h want=%h", obs, {1'b1, 64'd5, 4'b0000});
    end
    retire();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_ops();
    test_backpressure();
    test_back_to_back();
`ifdef ALU_MUL_EN
    test_mul();
`endif
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
